// File: rtl/rom_stream_reader.sv
// Streams consecutive words from a fixed-latency ROM onto a valid/ready interface.
// A credit counter bounds the reads in flight so the output FIFO never overflows.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]         DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]         PTR_ONE  = PW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic [CW-1:0]         credit_q;

  logic issue;
  logic issue_last;
  logic pop;

  // Credit covers both words in the ROM pipeline and words sitting in the FIFO.
  assign issue      = (state_q == S_RUN) && (credit_q < DEPTH_C);
  assign issue_last = issue && (remaining_q == REM_ONE);
  assign pop        = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (length == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_RUN;
              busy_q      <= 1'b1;
              addr_q      <= start_addr;
              remaining_q <= length;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            addr_q      <= addr_q + ADDR_ONE;
            remaining_q <= remaining_q - REM_ONE;
            if (issue_last) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop && m_last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   credit_q <= credit_q + CNT_ONE;
        2'b01:   credit_q <= credit_q - CNT_ONE;
        default: credit_q <= credit_q;
      endcase
    end
  end

  // {last, issue} travels alongside the ROM so the exiting entry matches rom_rd_data.
  logic [1:0] pipe_q [RD_LATENCY];
  logic [1:0] pipe_d [RD_LATENCY];

  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_d[gi] = {issue_last, issue};
      end else begin : g_tail
        assign pipe_d[gi] = pipe_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  logic wr_en;
  logic wr_last;
  assign wr_en   = pipe_q[RD_LATENCY-1][0];
  assign wr_last = pipe_q[RD_LATENCY-1][1];

  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic                  mem_last_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_data_q[wr_ptr_q] <= rom_rd_data;
        mem_last_q[wr_ptr_q] <= wr_last;
        wr_ptr_q             <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && (count_q == DEPTH_C)));

  assign busy     = busy_q;
  assign done     = done_q;
  assign rom_addr = addr_q;
  assign m_valid  = (count_q != '0);
  assign m_data   = mem_data_q[rd_ptr_q];
  assign m_last   = m_valid && mem_last_q[rd_ptr_q];

endmodule
